// File: rtl/lock_pkg.sv
// Shared encodings for the keypad lock and its supervisor.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam logic [3:0] KEY_A = 4'b0001;
  localparam logic [3:0] KEY_B = 4'b0010;
  localparam logic [3:0] KEY_C = 4'b0100;
  localparam logic [3:0] KEY_D = 4'b1000;

endpackage

// File: rtl/load_down_timer.sv
// Loadable down-counter shared by the open, lockout and entry-timeout phases.
module load_down_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Supervisor around the 4-key lock: gates keys, owns the lock reset, counts
// failed attempts, enforces lockout, auto-relocks and aborts stalled entries.
//
// state      | meaning
// IDLE       | keys forwarded to the lock, watching for unlock / failure / stall
// OPEN       | door open for OPEN_CYCLES, keys blocked
// LOCKOUT    | keys blocked for LOCKOUT_CYCLES after MAX_FAILS failures
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int FAIL_W         = 2,
  parameter int OPEN_CYCLES    = 50,
  parameter int LOCKOUT_CYCLES = 200,
  parameter int ENTRY_TIMEOUT  = 100,
  parameter int TIMER_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        keys,
  input  logic              unlock_in,
  input  logic [3:0]        progress_in,
  output logic [3:0]        keys_gated,
  output logic              lock_reset,
  output logic              door_open,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_count,
  output logic [1:0]        state_o
);

  localparam logic [TIMER_W-1:0] OPEN_LD    = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LD   = TIMER_W'(ENTRY_TIMEOUT - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);

  state_t             state;
  logic [3:0]         prev_progress;
  logic               fail_ev;
  logic               t_load;
  logic               t_dec;
  logic [TIMER_W-1:0] t_val;
  logic [TIMER_W-1:0] t_count;
  logic               t_zero;

  assign keys_gated = ((state == ST_IDLE) && !lock_reset) ? keys : 4'b0000;
  assign state_o    = state;

  // A partial entry collapsing to zero is a failure; our own lock resets are not.
  assign fail_ev = (state == ST_IDLE) && !lock_reset && !unlock_in &&
                   (prev_progress != 4'b0000) && (progress_in == 4'b0000);

  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = ENTRY_LD;
    case (state)
      ST_IDLE: begin
        if (unlock_in) begin
          t_load = 1'b1;
          t_val  = OPEN_LD;
        end else if (fail_ev && (fail_count == FAIL_LAST)) begin
          t_load = 1'b1;
          t_val  = LOCKOUT_LD;
        end else if (!fail_ev && (progress_in != 4'b0000) && (keys == 4'b0000) && !t_zero) begin
          t_dec = 1'b1;
        end else begin
          t_load = 1'b1;
        end
      end
      ST_OPEN, ST_LOCKOUT: begin
        if (t_zero) t_load = 1'b1;
        else        t_dec  = 1'b1;
      end
      default: t_load = 1'b1;
    endcase
  end

  load_down_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .count    (t_count),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      fail_count    <= '0;
      prev_progress <= 4'b0000;
      door_open     <= 1'b0;
      lockout       <= 1'b0;
      lock_reset    <= 1'b1;
    end else begin
      lock_reset    <= 1'b0;
      prev_progress <= lock_reset ? 4'b0000 : progress_in;
      case (state)
        ST_IDLE: begin
          if (unlock_in) begin
            state      <= ST_OPEN;
            door_open  <= 1'b1;
            fail_count <= '0;
            lock_reset <= (OPEN_CYCLES == 1);
          end else if (fail_ev && (fail_count == FAIL_LAST)) begin
            state      <= ST_LOCKOUT;
            lockout    <= 1'b1;
            fail_count <= FAIL_MAX;
            lock_reset <= 1'b1;
          end else if (fail_ev) begin
            if (fail_count < FAIL_MAX) fail_count <= fail_count + 1'b1;
          end else if ((progress_in != 4'b0000) && (keys == 4'b0000) && t_zero) begin
            lock_reset <= 1'b1;
          end
        end
        // Relock on the last open cycle so the lock is clear when IDLE resumes.
        ST_OPEN: begin
          if (t_zero) begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end else if (t_count == TIMER_W'(1)) begin
            lock_reset <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (t_zero) begin
            state      <= ST_IDLE;
            lockout    <= 1'b0;
            fail_count <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          door_open <= 1'b0;
          lockout   <= 1'b0;
        end
      endcase
    end
  end

endmodule
